// File: rtl/register_file.sv
// register_file
//   32 x 32-bit general-purpose register file. Two combinational read ports
//   and one synchronous write port. Register 0 always reads as zero.
//
//   Ports:
//     clk  - system clock; writes are captured on the rising edge
//     rst  - asynchronous reset, active-low; clears every register
//     A1   - read port 1 address
//     A2   - read port 2 address
//     A3   - write port address
//     WD3  - write data
//     WE3  - write enable, active-high
//     RD1  - read port 1 data (combinational)
//     RD2  - read port 2 data (combinational)
//
//   BYPASS=1 forwards WD3 to a read port whose address matches a pending
//   write in the same cycle; BYPASS=0 returns the stored value until the edge.
module register_file #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [WORD_SIZE-1:0]  WD3,
  input  logic                  WE3,
  output logic [WORD_SIZE-1:0]  RD1,
  output logic [WORD_SIZE-1:0]  RD2
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  // A write is live only out of reset and never to register 0.
  logic wr_live;
  assign wr_live = rst && WE3 && (A3 != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[A3] <= WD3;
    end
  end

  // Address 0 is forced to zero on the read side as well, so the read
  // result never depends on the contents of regs[0].
  always_comb begin
    RD1 = '0;
    if (A1 != '0) begin
      if ((BYPASS != 0) && wr_live && (A1 == A3)) begin
        RD1 = WD3;
      end else begin
        RD1 = regs[A1];
      end
    end
  end

  always_comb begin
    RD2 = '0;
    if (A2 != '0) begin
      if ((BYPASS != 0) && wr_live && (A2 == A3)) begin
        RD2 = WD3;
      end else begin
        RD2 = regs[A2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Drives one non-bypassing and one bypassing register_file from shared
//   inputs and compares both against an array-based reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] rd1, rd2, rd1b, rd2b;

  always #5 clk = ~clk;

  register_file #(.WORD_SIZE(32), .NUM_REGS(32), .ADDR_WIDTH(5), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .RD1(rd1), .RD2(rd2)
  );

  register_file #(.WORD_SIZE(32), .NUM_REGS(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_bp (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .RD1(rd1b), .RD2(rd2b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [32];

  typedef struct {
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd;
    logic        we;
    logic [31:0] exp1, exp2;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit bp);
    if (a == 5'd0) return 32'h0;
    if (bp && rst && we3 && (a3 != 5'd0) && (a == a3)) return wd3;
    return mdl[a];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %08h expected %08h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd1"},  rd1,  ref_rd(a1, 1'b0));
    check({tag, ".rd2"},  rd2,  ref_rd(a2, 1'b0));
    check({tag, ".rd1b"}, rd1b, ref_rd(a1, 1'b1));
    check({tag, ".rd2b"}, rd2b, ref_rd(a2, 1'b1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // Called at posedge+1; applies inputs, checks before and after the next edge.
  task automatic apply(input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] x3,
                       input logic [31:0] wd, input logic we, input string tag);
    a1 = x1; a2 = x2; a3 = x3; wd3 = wd; we3 = we;
    #1;
    check_model({tag, ".pre"});
    @(posedge clk);
    if (rst && we && (x3 != 5'd0)) mdl[x3] = wd;
    #1;
    check_model({tag, ".post"});
  endtask

  // Asynchronous reset pulse between edges (called at posedge+1).
  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    clear_model();
    check_model("rstpulse");
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; a1 = '0; a2 = 5'd5; a3 = '0; wd3 = '0; we3 = 1'b0;
    clear_model();

    // Reset then read
    #2;
    check("rst_low.rd1", rd1, 32'h0);
    check("rst_low.rd2", rd2, 32'h0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rel.rd1", rd1, 32'h0);
    check("rst_rel.rd2", rd2, 32'h0);

    // Write/read latency on r10
    a1 = 5'd10; a2 = 5'd10; a3 = 5'd10; wd3 = 32'hFFFF_FFFF; we3 = 1'b1;
    #1;
    check("wr_pre.rd1",  rd1,  32'h0);
    check("wr_pre.rd2",  rd2,  32'h0);
    check("wr_pre.rd1b", rd1b, 32'hFFFF_FFFF);
    check("wr_pre.rd2b", rd2b, 32'hFFFF_FFFF);
    @(posedge clk);
    mdl[10] = 32'hFFFF_FFFF;
    #1;
    check("wr_post.rd1", rd1, 32'hFFFF_FFFF);
    check("wr_post.rd2", rd2, 32'hFFFF_FFFF);

    // Hold with WE3=0
    for (int i = 0; i < 3; i++) begin
      apply(5'd10, 5'd10, 5'd10, 32'h1234_5678, 1'b0, "hold");
      check("hold.rd1", rd1, 32'hFFFF_FFFF);
    end

    // Async reset mid-cycle, then a write while reset is held
    a1 = 5'd10; we3 = 1'b0;
    #1;
    check("pre_async.rd1", rd1, 32'hFFFF_FFFF);
    rst = 1'b0;
    #1;
    clear_model();
    check("async.rd1",  rd1,  32'h0);
    check("async.rd1b", rd1b, 32'h0);
    a3 = 5'd10; wd3 = 32'hDEAD_BEEF; we3 = 1'b1;
    #1;
    check("wr_in_rst.rd1b", rd1b, 32'h0);
    @(posedge clk); #1;
    check("wr_in_rst.rd1", rd1, 32'h0);
    rst = 1'b1; we3 = 1'b0;
    #1;
    check("after_rst.rd1",  rd1,  32'h0);
    check("after_rst.rd1b", rd1b, 32'h0);
    @(posedge clk); #1;

    // Register 0 protection
    for (int i = 0; i < 3; i++) begin
      apply(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, "r0");
      check("r0.rd1",  rd1,  32'h0);
      check("r0.rd2b", rd2b, 32'h0);
    end

    // Table-driven vectors from a clean state; expectations are post-edge
    reset_pulse();
    @(posedge clk); #1;
    vecs[0] = '{5'd10, 5'd10, 5'd10, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1] = '{5'd10, 5'd0,  5'd10, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{5'd3,  5'd10, 5'd3,  32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
    vecs[3] = '{5'd3,  5'd31, 5'd31, 32'h0000_FFFF, 1'b1, 32'hA5A5_A5A5, 32'h0000_FFFF};
    vecs[4] = '{5'd31, 5'd3,  5'd7,  32'h7777_7777, 1'b0, 32'h0000_FFFF, 32'hA5A5_A5A5};
    vecs[5] = '{5'd0,  5'd0,  5'd0,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{5'd10, 5'd31, 5'd10, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_FFFF};
    foreach (vecs[i]) begin
      apply(vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].wd, vecs[i].we, "vec");
      check($sformatf("vec%0d.rd1", i), rd1, vecs[i].exp1);
      check($sformatf("vec%0d.rd2", i), rd2, vecs[i].exp2);
    end

    // Randomized traffic with occasional async reset pulses
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r1, r2, r3;
      if ($urandom_range(0, 39) == 0) reset_pulse();
      r1 = 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      r3 = ($urandom_range(0, 1) == 0) ? r1 : 5'($urandom_range(0, 31));
      apply(r1, r2, r3, $urandom, 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
